// File: rtl/hs32_regbank_pkg.sv
// Shared types and width helpers for the HS32 banked register file.
package hs32_regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLR_ALL  = 2'd1,
      ST_CLR_BANK = 2'd2
   } clr_state_e;

   function automatic int unsigned bank_w(input int unsigned nbank);
      return (nbank > 1) ? $clog2(nbank) : 1;
   endfunction

   // One spare bit over the entry count, so the pointer never has to wrap.
   function automatic int unsigned ptr_w(input int unsigned aw, input int unsigned nbank);
      return $clog2(nbank * (2 ** aw)) + 1;
   endfunction

endpackage

// File: rtl/hs32_regbank_clr.sv
// Clear sequencer: the whole-file sweep after reset and the single-bank sweep on request.
// One entry is zero-filled per cycle. busy stays high for as long as a sweep is running.
module hs32_regbank_clr
   import hs32_regbank_pkg::*;
#(
   parameter int unsigned AW    = 4,
   parameter int unsigned NBANK = 2,
   localparam int unsigned BW   = bank_w(NBANK)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [BW-1:0] start_bank,
   output logic          busy,
   output logic          cw_en,
   output logic [BW-1:0] cw_bank,
   output logic [AW-1:0] cw_adr
);

   localparam int unsigned PW = ptr_w(AW, NBANK);
   localparam logic [PW-1:0] LAST_ALL  = PW'(NBANK * (2 ** AW) - 1);
   localparam logic [PW-1:0] LAST_BANK = PW'((2 ** AW) - 1);

   clr_state_e    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [BW-1:0] bank_q, bank_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      bank_d  = bank_q;
      busy_d  = busy_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CLR_BANK;
               ptr_d   = '0;
               bank_d  = start_bank;
               busy_d  = 1'b1;
            end
         end
         ST_CLR_ALL: begin
            if (ptr_q == LAST_ALL) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               ptr_d = ptr_q + PW'(1);
            end
         end
         ST_CLR_BANK: begin
            if (ptr_q == LAST_BANK) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               ptr_d = ptr_q + PW'(1);
            end
         end
         default: begin
            state_d = ST_CLR_ALL;
            ptr_d   = '0;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_CLR_ALL;
         ptr_q   <= '0;
         bank_q  <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         bank_q  <= bank_d;
         busy_q  <= busy_d;
      end
   end

   // In the whole-file sweep the pointer's upper bits walk the banks.
   assign busy    = busy_q;
   assign cw_en   = (state_q != ST_IDLE);
   assign cw_bank = (state_q == ST_CLR_ALL) ? ptr_q[AW +: BW] : bank_q;
   assign cw_adr  = ptr_q[AW-1:0];

endmodule

// File: rtl/hs32_regbank.sv
// Banked register file with NRD registered read ports, one write port and hardware clear.
// Define HS32_REGBANK_BYPASS_EN for write-first read/write collisions; default is read-first.
module hs32_regbank
   import hs32_regbank_pkg::*;
#(
   parameter int unsigned AW    = 4,
   parameter int unsigned DW    = 32,
   parameter int unsigned NBANK = 2,
   parameter int unsigned NRD   = 2,
   localparam int unsigned BW   = bank_w(NBANK)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [BW-1:0]     wbank,
   input  logic [AW-1:0]     wadr,
   input  logic [DW-1:0]     din,
   input  logic              re,
   input  logic [BW-1:0]     rbank,
   input  logic [NRD*AW-1:0] radr,
   output logic [NRD*DW-1:0] dout,
   output logic              rvalid,
   input  logic              clr,
   output logic              busy
);

   localparam int unsigned NENT = NBANK * (2 ** AW);
   localparam int unsigned BW1  = BW + 1;
   localparam logic [BW:0] NBANK_L = BW1'(NBANK);

   logic [DW-1:0]    mem_q [NENT];
   logic             wbank_ok, rbank_ok;
   logic             clr_go, user_wr, rd_go;
   logic             cw_en;
   logic [BW-1:0]    cw_bank;
   logic [AW-1:0]    cw_adr;
   logic             wr_en;
   logic [BW+AW-1:0] wr_idx;
   logic [DW-1:0]    wr_data;
   logic             rvalid_q, rvalid_d;

   assign wbank_ok = ({1'b0, wbank} < NBANK_L);
   assign rbank_ok = ({1'b0, rbank} < NBANK_L);
   assign clr_go   = !busy && clr && wbank_ok;
   // A write arriving alongside a clear request is dropped.
   assign user_wr  = !busy && we && !clr && wbank_ok;
   assign rd_go    = !busy && re;

   hs32_regbank_clr #(
      .AW    (AW),
      .NBANK (NBANK)
   ) u_clr (
      .clk        (clk),
      .reset      (reset),
      .start      (clr_go),
      .start_bank (wbank),
      .busy       (busy),
      .cw_en      (cw_en),
      .cw_bank    (cw_bank),
      .cw_adr     (cw_adr)
   );

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      if (reset) begin
         if (cw_en) begin
            wr_en  = 1'b1;
            wr_idx = {cw_bank, cw_adr};
         end else if (user_wr) begin
            wr_en   = 1'b1;
            wr_idx  = {wbank, wadr};
            wr_data = din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] adr_k;
      logic [DW-1:0] dout_q, dout_d;

      assign adr_k = radr[k*AW +: AW];

      always_comb begin
         dout_d = dout_q;
         if (rd_go) begin
            dout_d = '0;
            if (rbank_ok) dout_d = mem_q[{rbank, adr_k}];
`ifdef HS32_REGBANK_BYPASS_EN
            if (user_wr && (rbank == wbank) && (adr_k == wadr)) dout_d = din;
`endif
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) dout_q <= '0;
         else        dout_q <= dout_d;
      end

      assign dout[k*DW +: DW] = dout_q;
   end

   assign rvalid_d = rd_go;

   always_ff @(posedge clk) begin
      if (!reset) rvalid_q <= 1'b0;
      else        rvalid_q <= rvalid_d;
   end

   assign rvalid = rvalid_q;

endmodule

// File: tb/tb_hs32_regbank.sv
// Self-checking bench for hs32_regbank: directed scenarios plus randomized traffic against a
// bank/array reference model. Honours HS32_REGBANK_BYPASS_EN for collision expectations.
module tb_hs32_regbank;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int NBANK = 2;
   localparam int NRD   = 2;
   localparam int DEPTH = 2 ** AW;

`ifdef HS32_REGBANK_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic              we;
   logic              wbank;
   logic [AW-1:0]     wadr;
   logic [DW-1:0]     din;
   logic              re;
   logic              rbank;
   logic [NRD*AW-1:0] radr;
   logic [NRD*DW-1:0] dout;
   logic              rvalid;
   logic              clr;
   logic              busy;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference model: plain storage, a remaining-busy-cycles counter and expected outputs.
   logic [DW-1:0] mem_m [NBANK][DEPTH];
   int            busy_m;
   logic [DW-1:0] exp_dout [NRD];
   logic          exp_rvalid;

   hs32_regbank #(
      .AW    (AW),
      .DW    (DW),
      .NBANK (NBANK),
      .NRD   (NRD)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .wbank  (wbank),
      .wadr   (wadr),
      .din    (din),
      .re     (re),
      .rbank  (rbank),
      .radr   (radr),
      .dout   (dout),
      .rvalid (rvalid),
      .clr    (clr),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step();
      logic [AW-1:0] a;
      if (!reset) begin
         busy_m     = NBANK * DEPTH;
         exp_rvalid = 1'b0;
         for (int k = 0; k < NRD; k++) exp_dout[k] = '0;
         for (int b = 0; b < NBANK; b++)
            for (int i = 0; i < DEPTH; i++) mem_m[b][i] = '0;
      end else if (busy_m > 0) begin
         busy_m     = busy_m - 1;
         exp_rvalid = 1'b0;
      end else begin
         exp_rvalid = re;
         if (re) begin
            for (int k = 0; k < NRD; k++) begin
               a = radr[k*AW +: AW];
               exp_dout[k] = (int'(rbank) < NBANK) ? mem_m[rbank][a] : '0;
               if (BYPASS && we && !clr && rbank == wbank && a == wadr) exp_dout[k] = din;
            end
         end
         if (clr && int'(wbank) < NBANK) begin
            for (int i = 0; i < DEPTH; i++) mem_m[wbank][i] = '0;
            busy_m = DEPTH;
         end else if (we && int'(wbank) < NBANK) begin
            mem_m[wbank][wadr] = din;
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      we = 1'b0; re = 1'b0; clr = 1'b0;
   endtask

   task automatic wr(input logic b, input logic [AW-1:0] a, input logic [DW-1:0] d);
      quiet();
      we = 1'b1; wbank = b; wadr = a; din = d;
      step();
      quiet();
   endtask

   task automatic rd(input logic b, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      quiet();
      re = 1'b1; rbank = b; radr = {a1, a0};
      step();
      quiet();
   endtask

   task automatic test_reset();
      int n;
      int rv_bad;
      quiet();
      wbank = 1'b0; wadr = '0; din = '0; rbank = 1'b0; radr = '0;
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      n_cmp++;
      if (dout !== '0 || rvalid !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: dout=%h rvalid=%b busy=%b, want 0/0/1", dout, rvalid, busy);
      end
      re = 1'b1;
      n = 0; rv_bad = 0;
      while (busy === 1'b1 && n < 100) begin
         if (rvalid !== 1'b0) rv_bad++;
         n++;
         step();
      end
      re = 1'b0;
      n_cmp++;
      if (n != 32) begin
         n_err++;
         $display("FAIL reset_busy_len: got %0d cycles, want 32", n);
      end
      n_cmp++;
      if (rv_bad != 0) begin
         n_err++;
         $display("FAIL reset_rvalid_busy: %0d cycles with rvalid=1, want 0", rv_bad);
      end
      for (int b = 0; b < NBANK; b++) begin
         for (int a = 0; a < DEPTH; a += 2) begin
            rd(b[0], AW'(a), AW'(a + 1));
            n_cmp++;
            if (dout !== '0 || rvalid !== 1'b1) begin
               n_err++;
               $display("FAIL reset_zero b%0d r%0d: dout=%h rvalid=%b, want 0/1", b, a, dout, rvalid);
            end
         end
      end
   endtask

   task automatic test_write_read();
      wr(1'b0, 4'd5, 32'hDEADBEEF);
      rd(1'b0, 4'd5, 4'd5);
      n_cmp++;
      if (dout !== {32'hDEADBEEF, 32'hDEADBEEF} || rvalid !== 1'b1) begin
         n_err++;
         $display("FAIL write_read: dout=%h rvalid=%b, want deadbeefdeadbeef/1", dout, rvalid);
      end
      step();
      n_cmp++;
      if (rvalid !== 1'b0 || dout !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL read_hold: dout=%h rvalid=%b, want deadbeefdeadbeef/0", dout, rvalid);
      end
   endtask

   task automatic test_bank_isolation();
      wr(1'b1, 4'd5, 32'h12345678);
      rd(1'b0, 4'd5, 4'd5);
      n_cmp++;
      if (dout[31:0] !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL bank0_r5: got %h, want deadbeef", dout[31:0]);
      end
      rd(1'b1, 4'd5, 4'd0);
      n_cmp++;
      if (dout !== {32'h0, 32'h12345678}) begin
         n_err++;
         $display("FAIL bank1_r5: got %h, want 0000000012345678", dout);
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] want;
      want = BYPASS ? 32'h2 : 32'h1;
      wr(1'b0, 4'd3, 32'h1);
      quiet();
      we = 1'b1; wbank = 1'b0; wadr = 4'd3; din = 32'h2;
      re = 1'b1; rbank = 1'b0; radr = {4'd3, 4'd3};
      step();
      quiet();
      n_cmp++;
      if (dout !== {want, want} || rvalid !== 1'b1) begin
         n_err++;
         $display("FAIL collision: dout=%h rvalid=%b, want %h x2 /1", dout, rvalid, want);
      end
      rd(1'b0, 4'd3, 4'd3);
      n_cmp++;
      if (dout !== {32'h2, 32'h2}) begin
         n_err++;
         $display("FAIL collision_after: got %h, want 0000000200000002", dout);
      end
   endtask

   task automatic test_clr_bank();
      int n;
      int bad;
      quiet();
      clr = 1'b1; we = 1'b1; wbank = 1'b1; wadr = 4'd7; din = 32'hFF;
      step();
      quiet();
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         step();
      end
      n_cmp++;
      if (n != 16) begin
         n_err++;
         $display("FAIL clr_busy_len: got %0d cycles, want 16", n);
      end
      bad = 0;
      for (int a = 0; a < DEPTH; a += 2) begin
         rd(1'b1, AW'(a), AW'(a + 1));
         if (dout !== '0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL clr_bank1_zero: %0d nonzero reads, want 0", bad);
      end
      rd(1'b0, 4'd5, 4'd3);
      n_cmp++;
      if (dout !== {32'h2, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL clr_bank0_kept: got %h, want 00000002deadbeef", dout);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         we    = 1'($urandom_range(0, 1));
         re    = ($urandom_range(0, 9) < 6);
         clr   = ($urandom_range(0, 99) < 3);
         wbank = 1'($urandom_range(0, 1));
         rbank = ($urandom_range(0, 1) == 0) ? wbank : 1'($urandom_range(0, 1));
         wadr  = AW'($urandom_range(0, DEPTH - 1));
         din   = $urandom;
         radr[AW-1:0]  = ($urandom_range(0, 1) == 0) ? wadr : AW'($urandom_range(0, DEPTH - 1));
         radr[2*AW-1:AW] = AW'($urandom_range(0, DEPTH - 1));
         step();
         n_cmp++;
         if (busy !== (busy_m > 0) || rvalid !== exp_rvalid) begin
            n_err++;
            $display("FAIL rand_ctl c%0d: busy=%b rvalid=%b, want %b/%b", c, busy, rvalid, busy_m > 0, exp_rvalid);
         end
         for (int k = 0; k < NRD; k++) begin
            n_cmp++;
            if (dout[k*DW +: DW] !== exp_dout[k]) begin
               n_err++;
               $display("FAIL rand_dout c%0d p%0d: got %h, want %h", c, k, dout[k*DW +: DW], exp_dout[k]);
            end
         end
      end
      quiet();
      while (busy_m > 0) step();
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      int rv_bad;
      quiet();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      repeat (10) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      re = 1'b1; rbank = 1'b0; radr = '0;
      n = 0; rv_bad = 0;
      while (busy === 1'b1 && n < 100) begin
         if (rvalid !== 1'b0) rv_bad++;
         n++;
         step();
      end
      quiet();
      n_cmp++;
      if (n != 32) begin
         n_err++;
         $display("FAIL midsweep_busy_len: got %0d cycles, want 32", n);
      end
      n_cmp++;
      if (rv_bad != 0) begin
         n_err++;
         $display("FAIL midsweep_rvalid: %0d cycles with rvalid=1, want 0", rv_bad);
      end
      rd(1'b0, 4'd5, 4'd3);
      n_cmp++;
      if (dout !== '0 || rvalid !== 1'b1) begin
         n_err++;
         $display("FAIL midsweep_zero: dout=%h rvalid=%b, want 0/1", dout, rvalid);
      end
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_write_read();
      test_bank_isolation();
      test_collision();
      test_clr_bank();
      test_random();
      test_reset_mid_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
